// File: rtl/hello_pkg.sv
// Shared definitions for the HELLO rotating display: scroll FSM encodings,
// position geometry and the 7-segment glyphs used by the decoder.
package hello_pkg;

  localparam int NUM_POS = 8;
  localparam int POS_W   = 3;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCROLL = 2'b01,
    ST_DWELL  = 2'b10
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a} as wired on the DE2 HEX displays.
  localparam logic [6:0] GLYPH_H     = 7'b0001001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_L     = 7'b1000111;
  localparam logic [6:0] GLYPH_O     = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // With NUM_POS a power of two the modulo falls out of the natural wrap.
  function automatic pos_t step_pos(input pos_t p, input logic dir);
    return dir ? pos_t'(p - pos_t'(1)) : pos_t'(p + pos_t'(1));
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV enabled cycles,
// restarted from zero whenever disabled or cleared.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset || clr || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Rotation sequencer for the HELLO display: steps the 3-bit select left or
// right at the prescaled rate, with run/stop, direct load and a home dwell.
module hello_scroll_ctrl
  import hello_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int DWELL_TICKS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             dir,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             wrap,
  output logic [1:0]       state
);

  localparam int            DW         = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_TICKS > 0) ? DWELL_TICKS - 1 : 0);

  state_t        state_q, state_d;
  pos_t          pos_q, pos_d, stepped;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;
  logic [DW-1:0] dwell_q;
  logic          tick, active, clr;
  logic          scroll_tick, dwell_done;

  assign active      = (state_q == ST_SCROLL) || (state_q == ST_DWELL);
  assign stepped     = step_pos(pos_q, dir);
  // Load outranks a coincident tick; dropping Run discards it.
  assign scroll_tick = (state_q == ST_SCROLL) && run && tick && !load;
  assign dwell_done  = (state_q == ST_DWELL) && tick && (dwell_q == DWELL_LAST);
  assign clr         = load || (state_d != state_q);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .en   (active),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run && !load) state_d = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (scroll_tick && (stepped == '0) && (DWELL_TICKS > 0)) begin
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (load || dwell_done) begin
          state_d = ST_SCROLL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pos_d  = pos_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      pos_d = load_pos;
    end else if (scroll_tick) begin
      pos_d  = stepped;
      step_d = 1'b1;
      wrap_d = (stepped == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  // Held at zero outside DWELL, which gives the clear-on-entry for free.
  always_ff @(posedge clock) begin
    if (reset || (state_q != ST_DWELL)) begin
      dwell_q <= '0;
    end else if (tick) begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  assign pos   = pos_q;
  assign step  = step_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule
